huff_bitstream_aligner: RTL and testbench

- Parametrised bitstream front-end for the Huffman decoder.
- Accepts packed, MSB-first encoded words from upstream through a valid/ready handshake.
- Presents a left-aligned window of the next WIN_W unconsumed bits to the decoder, then discards a variable number of bits each cycle as the decoder reports symbol lengths.
- Replaces the fixed 6-bit feeder with generic widths, backpressure, end-of-stream draining, flush and error reporting.

---
 rtl/huff_pkg.sv | 22 ++
 rtl/huff_shift_buf.sv | 63 ++++++
 rtl/huff_bitstream_aligner.sv | 122 ++++++++++++
 tb/tb_huff_bitstream_aligner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman decoder front-end.
//   MAX_CODE_LEN : longest code/escape the decoder can see (window width).
//   huff_len_w() : minimum width of a length field able to hold 0..win_w.
//   huff_state_e : stream state of the bitstream aligner.
package huff_pkg;

    localparam int MAX_CODE_LEN = 6;

    function automatic int huff_len_w(input int win_w);
        return $clog2(win_w + 1);
    endfunction

    localparam int HUFF_LEN_W = huff_len_w(MAX_CODE_LEN);

    typedef enum logic [1:0] {
        FILL  = 2'd0,   // not enough bits for a full window, stream still open
        RUN   = 2'd1,   // at least one full window buffered
        DRAIN = 2'd2,   // stream closed, short tail left
        DONE  = 2'd3    // stream closed, every bit consumed
    } huff_state_e;

endpackage

// File: rtl/huff_shift_buf.sv
// Left-aligned shift buffer holding the unconsumed bits of the stream.
//   clk, rst        : clock, synchronous active-low reset
//   clear_i         : synchronous clear (flush)
//   shift_len_i     : bits to discard this cycle (already validated, 0 = none)
//   append_en_i     : append append_data_i behind the remaining bits
//   append_data_i   : word to append, MSB first
//   win_o           : top WIN_W bits of the buffer (oldest bit at MSB)
//   level_o         : current fill level
//   level_next_o    : fill level after this cycle's shift and append
// Bits below the fill level are always zero, so an append can be OR-ed in.
module huff_shift_buf #(
    parameter int IN_W  = 32,
    parameter int WIN_W = 6,
    parameter int BUF_W = 64,
    parameter int LEN_W = 4,
    parameter int LVL_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic [LEN_W-1:0] shift_len_i,
    input  logic             append_en_i,
    input  logic [IN_W-1:0]  append_data_i,
    output logic [WIN_W-1:0] win_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_next_o
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] append_aligned;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] level_shifted;

    // Shift first, then append at the reduced level, so a same-cycle
    // consume and accept neither lose nor duplicate bits.
    always_comb begin
        shifted        = buf_q << shift_len_i;
        level_shifted  = level_q - LVL_W'(shift_len_i);
        append_aligned = {append_data_i, {(BUF_W-IN_W){1'b0}}} >> level_shifted;
        buf_d          = shifted;
        level_d        = level_shifted;
        if (append_en_i) begin
            buf_d   = shifted | append_aligned;
            level_d = level_shifted + LVL_W'(IN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            buf_q   <= '0;
            level_q <= '0;
        end else begin
            buf_q   <= buf_d;
            level_q <= level_d;
        end
    end

    assign win_o        = buf_q[BUF_W-1 -: WIN_W];
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/huff_bitstream_aligner.sv
// Bitstream front-end for the Huffman decoder.
//   clk, rst        : clock, synchronous active-low reset
//   flush           : synchronous clear of buffer and stream state
//   in_data/in_valid/in_last/in_ready : upstream word handshake
//   win_data        : next WIN_W unconsumed bits, oldest at MSB, zero padded
//   win_bits        : meaningful bits in win_data, saturated at WIN_W
//   win_valid       : decoder may decode and consume this cycle
//   consume_en/consume_len : bits discarded by the decoder this cycle
//   stream_done     : last word accepted and fully consumed (sticky)
//   err_overconsume : one-cycle pulse after a rejected consume
//   dbg_state_o     : current stream state
//   dbg_level_o     : current buffer fill level
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready depends on registers only, and upstream holds in_data/in_valid
// stable until the transfer. A consume is honoured on a rising edge where
// consume_en && win_valid && 1 <= consume_len <= win_bits; len 0 is a no-op.
module huff_bitstream_aligner
    import huff_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int WIN_W = MAX_CODE_LEN,
    parameter int BUF_W = 64,
    parameter int LEN_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [WIN_W-1:0]             win_data,
    output logic [LEN_W-1:0]             win_bits,
    output logic                         win_valid,
    input  logic                         consume_en,
    input  logic [LEN_W-1:0]             consume_len,
    output logic                         stream_done,
    output logic                         err_overconsume,
    output huff_state_e                  dbg_state_o,
    output logic [$clog2(BUF_W+1)-1:0]   dbg_level_o
);

    localparam int LVL_W = $clog2(BUF_W + 1);

    huff_state_e      state_q, state_d;
    logic             last_seen_q, last_seen_d;
    logic             err_q, err_d;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             accept;
    logic             consume_req;
    logic             consume_ok;
    logic [LEN_W-1:0] shift_len;

    // Window view and upstream readiness, all from registered state.
    always_comb begin
        in_ready  = !last_seen_q && (level <= LVL_W'(BUF_W - IN_W));
        win_valid = (level >= LVL_W'(WIN_W)) || (last_seen_q && (level != '0));
        win_bits  = (level >= LVL_W'(WIN_W)) ? LEN_W'(WIN_W) : LEN_W'(level);
    end

    // win_bits never exceeds WIN_W, so this also rejects len > WIN_W.
    // In DONE win_valid is 0, so any non-zero consume is rejected.
    always_comb begin
        accept      = in_valid && in_ready;
        consume_req = consume_en && (consume_len != '0);
        consume_ok  = consume_req && win_valid && (consume_len <= win_bits);
        shift_len   = consume_ok ? consume_len : '0;
        err_d       = consume_req && !consume_ok;
        last_seen_d = last_seen_q || (accept && in_last);
    end

    huff_shift_buf #(
        .IN_W  (IN_W),
        .WIN_W (WIN_W),
        .BUF_W (BUF_W),
        .LEN_W (LEN_W),
        .LVL_W (LVL_W)
    ) u_shift_buf (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (flush),
        .shift_len_i   (shift_len),
        .append_en_i   (accept),
        .append_data_i (in_data),
        .win_o         (win_data),
        .level_o       (level),
        .level_next_o  (level_next)
    );

    // State follows the next-cycle level and last flag. DONE is sticky
    // because nothing can be accepted or consumed once it is reached.
    always_comb begin
        state_d = FILL;
        if (last_seen_d && (level_next == '0)) begin
            state_d = DONE;
        end else if (level_next >= LVL_W'(WIN_W)) begin
            state_d = RUN;
        end else if (last_seen_d) begin
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state_q     <= FILL;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

    assign stream_done     = (state_q == DONE);
    assign err_overconsume = err_q;
    assign dbg_state_o     = state_q;
    assign dbg_level_o     = level;

endmodule

// File: tb/tb_huff_bitstream_aligner.sv
module tb_huff_bitstream_aligner;
  import huff_pkg::*;

  localparam int IN_W  = 32;
  localparam int WIN_W = 6;
  localparam int BUF_W = 64;
  localparam int LEN_W = 4;
  localparam int LVL_W = $clog2(BUF_W + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIN_W-1:0] win_data;
  logic [LEN_W-1:0] win_bits;
  logic             win_valid;
  logic             consume_en;
  logic [LEN_W-1:0] consume_len;
  logic             stream_done;
  logic             err_overconsume;
  huff_state_e      dbg_state;
  logic [LVL_W-1:0] dbg_level;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [59:0] rd;

  huff_bitstream_aligner #(
    .IN_W  (IN_W),
    .WIN_W (WIN_W),
    .BUF_W (BUF_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .win_data        (win_data),
    .win_bits        (win_bits),
    .win_valid       (win_valid),
    .consume_en      (consume_en),
    .consume_len     (consume_len),
    .stream_done     (stream_done),
    .err_overconsume (err_overconsume),
    .dbg_state_o     (dbg_state),
    .dbg_level_o     (dbg_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push(input logic [IN_W-1:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input int len);
    consume_en  = 1'b1;
    consume_len = LEN_W'(len);
    step();
    consume_en  = 1'b0;
    consume_len = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_data = 32'hA5A5A5A5; in_valid = 1'b1;
    in_last = 1'b0; consume_en = 1'b0; consume_len = '0;

    // reset held with in_valid asserted
    repeat (3) step();
    check("rst_in_ready",  64'(in_ready),    64'(1));
    check("rst_win_valid", 64'(win_valid),   64'(0));
    check("rst_win_bits",  64'(win_bits),    64'(0));
    check("rst_win_data",  64'(win_data),    64'(0));
    check("rst_done",      64'(stream_done), 64'(0));
    check("rst_level",     64'(dbg_level),   64'(0));
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    check("first_win_data", 64'(win_data),  64'(6'b101001));
    check("first_win_bits", 64'(win_bits),  64'(6));
    check("first_level",    64'(dbg_level), 64'(32));
    check("first_state",    64'(dbg_state), 64'(RUN));

    // variable consume: stream 11110000 repeated
    do_flush();
    push(32'hF0F0F0F0, 1'b0);
    check("vc_win0", 64'(win_data), 64'(6'b111100));
    check("vc_lvl0", 64'(dbg_level), 64'(32));
    consume(4);
    check("vc_win1", 64'(win_data), 64'(6'b000011));
    check("vc_lvl1", 64'(dbg_level), 64'(28));
    consume(6);
    check("vc_win2", 64'(win_data), 64'(6'b110000));
    check("vc_lvl2", 64'(dbg_level), 64'(22));
    consume(1);
    check("vc_win3", 64'(win_data), 64'(6'b100001));
    check("vc_lvl3", 64'(dbg_level), 64'(21));
    consume(5);
    check("vc_win4", 64'(win_data), 64'(6'b111100));
    check("vc_lvl4", 64'(dbg_level), 64'(16));

    // simultaneous accept and consume at level 30
    do_flush();
    push(32'h12345678, 1'b0);
    consume(2);
    check("sim_lvl30", 64'(dbg_level), 64'(30));
    in_data = 32'hCAFEBABE; in_valid = 1'b1;
    consume(6);
    in_valid = 1'b0;
    check("sim_lvl56",  64'(dbg_level), 64'(56));
    check("sim_ready0", 64'(in_ready),  64'(0));
    rd = '0;
    for (int i = 0; i < 10; i++) begin
      rd = {rd[53:0], win_data};
      if (i < 9) consume(6);
    end
    check("sim_stream", 64'(rd), 64'(60'h345678CAFEBABE0));
    check("sim_tail_lvl",   64'(dbg_level), 64'(2));
    check("sim_tail_valid", 64'(win_valid), 64'(0));
    check("sim_tail_bits",  64'(win_bits),  64'(2));

    // backpressure: in_valid held, no consumes
    do_flush();
    in_data = 32'h11111111; in_valid = 1'b1;
    repeat (4) step();
    check("bp_lvl64", 64'(dbg_level), 64'(64));
    check("bp_ready", 64'(in_ready),  64'(0));
    consume_en = 1'b1; consume_len = 4'd6;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("bp_drain_lvl",   64'(dbg_level), 64'(64 - 6*i));
      check("bp_drain_ready", 64'(in_ready),  64'((64 - 6*i) <= 32));
    end
    consume_en = 1'b0; consume_len = '0;
    step();
    in_valid = 1'b0;
    check("bp_reaccept_lvl", 64'(dbg_level), 64'(60));

    // tail, drain and done
    do_flush();
    push(32'h80000001, 1'b1);
    check("tl_lvl",   64'(dbg_level), 64'(32));
    check("tl_state", 64'(dbg_state), 64'(RUN));
    check("tl_ready", 64'(in_ready),  64'(0));
    check("tl_win",   64'(win_data),  64'(6'b100000));
    for (int i = 0; i < 5; i++) consume(6);
    check("dr_state", 64'(dbg_state),   64'(DRAIN));
    check("dr_bits",  64'(win_bits),    64'(2));
    check("dr_win",   64'(win_data),    64'(6'b010000));
    check("dr_valid", 64'(win_valid),   64'(1));
    check("dr_done",  64'(stream_done), 64'(0));
    consume(2);
    check("dn_done",  64'(stream_done), 64'(1));
    check("dn_lvl",   64'(dbg_level),   64'(0));
    check("dn_valid", 64'(win_valid),   64'(0));
    consume(1);
    check("dn_err",   64'(err_overconsume), 64'(1));
    step();
    check("dn_err_clr", 64'(err_overconsume), 64'(0));
    check("dn_sticky",  64'(stream_done),     64'(1));

    // illegal consume, zero-length consume, flush with accept
    do_flush();
    check("fl_done_clr", 64'(stream_done), 64'(0));
    check("fl_ready",    64'(in_ready),    64'(1));
    consume(1);
    check("fill_err", 64'(err_overconsume), 64'(1));
    push(32'hDEADBEEF, 1'b0);
    check("il_lvl0", 64'(dbg_level), 64'(32));
    consume(7);
    check("il_err", 64'(err_overconsume), 64'(1));
    check("il_lvl", 64'(dbg_level),       64'(32));
    check("il_win", 64'(win_data),        64'(6'b110111));
    step();
    check("il_err_clr", 64'(err_overconsume), 64'(0));
    consume(0);
    check("z_err", 64'(err_overconsume), 64'(0));
    check("z_lvl", 64'(dbg_level),       64'(32));
    flush = 1'b1; in_data = 32'h12345678; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fa_lvl",   64'(dbg_level), 64'(0));
    check("fa_state", 64'(dbg_state), 64'(FILL));
    check("fa_ready", 64'(in_ready),  64'(1));
    check("fa_valid", 64'(win_valid), 64'(0));
    step();
    check("fa_lvl_hold", 64'(dbg_level), 64'(0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
